// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Lets two requesters share one external ALU. Only one operation is in
// flight at a time. The flow is IDLE (grant and accept), then EXEC (the
// operands are held on the ALU for ALU_LAT clocks), then RESP (the captured
// result is held until the served port consumes it). When both ports
// request together, a round-robin pointer picks the port that did not win
// last time.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  // Clocks from driving the ALU operands to sampling its result (1..4).
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,

  // Port 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_fn,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_y,
  output logic [2:0]  rsp0_zvn,

  // Port 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_fn,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_y,
  output logic [2:0]  rsp1_zvn,

  // Shared ALU
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fn,
  input  logic [31:0] alu_y,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Value loaded into the latency counter on accept.
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  fn_q, fn_d;
  logic [31:0] y_q, y_d;
  logic [2:0]  zvn_q, zvn_d;
  logic [2:0]  cnt_q, cnt_d;
  // Port currently being served (valid in EXEC and RESP).
  logic        port_q, port_d;
  // Port that wins when both request together. Resets to port 0.
  logic        prio_q, prio_d;

  logic        gnt_port;
  logic        accept;
  logic        rsp_hs;

  // Pick a winner among the valid requesters and raise ready only for it.
  // Ready is masked by reset_n, so it stays low while reset is asserted and
  // the first accept can only happen on a clock edge with reset released.
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_port = prio_q;
    end else begin
      gnt_port = req1_valid;
    end
    accept     = reset_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !gnt_port;
    req1_ready = accept &&  gnt_port;
  end

  // The served port consumes the response.
  always_comb begin
    rsp_hs = (state_q == ST_RESP) && (port_q ? rsp1_ready : rsp0_ready);
  end

  // Next-state logic: accept and register operands, count down the ALU
  // latency, capture the result, then wait for the response handshake.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. A path that
    // left one unassigned would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fn_d    = fn_q;
    y_d     = y_q;
    zvn_d   = zvn_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    prio_d  = prio_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = gnt_port ? req1_a  : req0_a;
          b_d     = gnt_port ? req1_b  : req0_b;
          fn_d    = gnt_port ? req1_fn : req0_fn;
          port_d  = gnt_port;
          cnt_d   = LAT_INIT;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          y_d     = alu_y;
          zvn_d   = {alu_z, alu_v, alu_n};
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_hs) begin
          // The port just served loses the next tie.
          prio_d  = ~port_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the operand and result registers are reset as well as the
      // control state. They drive alu_* directly, and all outputs must read
      // zero while reset is asserted.
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fn_q    <= '0;
      y_q     <= '0;
      zvn_q   <= '0;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fn_q    <= fn_d;
      y_q     <= y_d;
      zvn_q   <= zvn_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      prio_q  <= prio_d;
    end
  end

  // Drive the ALU from the registered operands. They only change on accept,
  // so they stay stable for all of EXEC. fn is passed through uninterpreted.
  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_fn = fn_q;
  end

  // Present the response on the served port only. Data reads zero whenever
  // a port's valid is low.
  always_comb begin
    rsp0_valid = (state_q == ST_RESP) && !port_q;
    rsp1_valid = (state_q == ST_RESP) &&  port_q;
    rsp0_y     = rsp0_valid ? y_q   : '0;
    rsp0_zvn   = rsp0_valid ? zvn_q : '0;
    rsp1_y     = rsp1_valid ? y_q   : '0;
    rsp1_zvn   = rsp1_valid ? zvn_q : '0;
  end

  // -------------------------------------------------------------------------
  // Protocol invariants
  // -------------------------------------------------------------------------

  a_ready_excl : assert property (@(posedge clk) disable iff (!reset_n)
    !(req0_ready && req1_ready));

  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!reset_n)
    (req0_ready |-> req0_valid) and (req1_ready |-> req1_valid));

  a_rsp_excl : assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp0_valid && rsp1_valid));

  a_cnt_range : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ST_EXEC) |-> (cnt_q >= 3'd1 && cnt_q <= LAT_INIT));

  a_alu_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ST_EXEC && cnt_q != LAT_INIT) |-> $stable({alu_a, alu_b, alu_fn}));

  a_rsp_hold : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ST_RESP && !rsp_hs) |=>
      (state_q == ST_RESP && $stable(y_q) && $stable(zvn_q) && $stable(port_q)));

  a_rsp_zero : assert property (@(posedge clk) disable iff (!reset_n)
    (!rsp0_valid |-> (rsp0_y == '0 && rsp0_zvn == '0)) and
    (!rsp1_valid |-> (rsp1_y == '0 && rsp1_zvn == '0)));

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Two arbiter instances share one clock: instance 0 uses ALU_LAT=1 and
// instance 1 uses ALU_LAT=3. A behavioural ALU sits behind each instance.
// Stimulus is a table of single transactions, hand-written sequences for
// round-robin, backpressure and reset abort, and random traffic. Random
// traffic is checked against a model of the grant order and of the expected
// result.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [5:0] FN_ADD = 6'b010000;
  localparam logic [5:0] FN_SUB = 6'b010001;

  logic        clk;
  logic        reset_n   [2];
  logic        req_valid [2][2];
  logic [31:0] req_a     [2][2];
  logic [31:0] req_b     [2][2];
  logic [5:0]  req_fn    [2][2];
  logic        rsp_ready [2][2];

  wire         req_ready [2][2];
  wire         rsp_valid [2][2];
  wire  [31:0] rsp_y     [2][2];
  wire  [2:0]  rsp_zvn   [2][2];
  wire  [31:0] alu_a     [2];
  wire  [31:0] alu_b     [2];
  wire  [5:0]  alu_fn    [2];
  wire  [34:0] alu_res   [2];

  int   n_checks;
  int   n_fail;
  logic last_srv [2];

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fn;
    logic [31:0] y;
    logic [2:0]  zvn;
  } vec_t;

  vec_t vecs [8];

  // Behavioural ALU: returns {y, Z, V, N}. ADD and SUB are arithmetic, and
  // any other code yields a ^ b.
  function automatic logic [34:0] alu_fun(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] fn);
    logic [31:0] y;
    logic        v;
    case (fn)
      FN_ADD: begin
        y = a + b;
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      FN_SUB: begin
        y = a - b;
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      default: begin
        y = a ^ b;
        v = 1'b0;
      end
    endcase
    return {y, (y == 32'd0), v, y[31]};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign alu_res[g] = alu_fun(alu_a[g], alu_b[g], alu_fn[g]);

    alu_arbiter #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n[g]),
      .req0_valid (req_valid[g][0]),
      .req0_ready (req_ready[g][0]),
      .req0_a     (req_a[g][0]),
      .req0_b     (req_b[g][0]),
      .req0_fn    (req_fn[g][0]),
      .rsp0_valid (rsp_valid[g][0]),
      .rsp0_ready (rsp_ready[g][0]),
      .rsp0_y     (rsp_y[g][0]),
      .rsp0_zvn   (rsp_zvn[g][0]),
      .req1_valid (req_valid[g][1]),
      .req1_ready (req_ready[g][1]),
      .req1_a     (req_a[g][1]),
      .req1_b     (req_b[g][1]),
      .req1_fn    (req_fn[g][1]),
      .rsp1_valid (rsp_valid[g][1]),
      .rsp1_ready (rsp_ready[g][1]),
      .rsp1_y     (rsp_y[g][1]),
      .rsp1_zvn   (rsp_zvn[g][1]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_fn     (alu_fn[g]),
      .alu_y      (alu_res[g][34:3]),
      .alu_z      (alu_res[g][2]),
      .alu_v      (alu_res[g][1]),
      .alu_n      (alu_res[g][0])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // OR of every output of instance k.
  function automatic logic any_out(input int k);
    return |{req_ready[k][0], req_ready[k][1], rsp_valid[k][0], rsp_valid[k][1],
             rsp_y[k][0], rsp_y[k][1], rsp_zvn[k][0], rsp_zvn[k][1],
             alu_a[k], alu_b[k], alu_fn[k]};
  endfunction

  task automatic set_req(input int k, input int p, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] fn);
    req_valid[k][p] = 1'b1;
    req_a[k][p]     = a;
    req_b[k][p]     = b;
    req_fn[k][p]    = fn;
  endtask

  // One complete transaction on instance k, expected to be granted to port p.
  // Call it in an IDLE cycle with the request inputs already driven. It
  // returns in the IDLE cycle after the response handshake.
  task automatic serve(input int k, input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] fn, input logic [31:0] ey, input logic [2:0] ez,
                       input int hold, input bit raise_other);
    int q;
    q = 1 - p;
    #1;
    check("grant", {req_ready[k][1], req_ready[k][0]}, (p == 1) ? 2'b10 : 2'b01);
    step();
    // The requester drops valid and scrambles its operands after accept.
    req_valid[k][p] = 1'b0;
    req_a[k][p]     = $urandom;
    req_b[k][p]     = $urandom;
    req_fn[k][p]    = 6'($urandom);
    if (raise_other) req_valid[k][q] = 1'b1;
    for (int c = 0; c < lat_of(k); c++) begin
      #1;
      check("alu_ops", {alu_a[k], alu_b[k], alu_fn[k]}, {a, b, fn});
      check("exec_quiet", {rsp_valid[k][1], rsp_valid[k][0], req_ready[k][1], req_ready[k][0]},
            4'b0000);
      step();
    end
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) rsp_ready[k][p] = 1'b1;
      #1;
      check("rsp_valid", {rsp_valid[k][1], rsp_valid[k][0], req_ready[k][1], req_ready[k][0]},
            (p == 1) ? 4'b1000 : 4'b0100);
      check("rsp_data", {rsp_y[k][p], rsp_zvn[k][p]}, {ey, ez});
      check("rsp_other_zero", {rsp_y[k][q], rsp_zvn[k][q]}, 35'd0);
      step();
    end
    rsp_ready[k][p] = 1'b0;
  endtask

  initial begin
    logic [34:0] exp_r;
    logic [1:0]  pat;
    int          win;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{0, 32'd5,          32'd3,          FN_ADD,    32'd8,          3'b000};
    vecs[1] = '{0, 32'd7,          32'd7,          FN_SUB,    32'd0,          3'b100};
    vecs[2] = '{1, 32'd1,          32'd1,          FN_ADD,    32'd2,          3'b000};
    vecs[3] = '{1, 32'h7fff_ffff,  32'd1,          FN_ADD,    32'h8000_0000,  3'b011};
    vecs[4] = '{0, 32'd0,          32'd1,          FN_SUB,    32'hffff_ffff,  3'b001};
    vecs[5] = '{1, 32'hf0f0_f0f0,  32'h0f0f_0f0f,  6'b111111, 32'hffff_ffff,  3'b001};
    vecs[6] = '{0, 32'h1234_5678,  32'h1234_5678,  6'b000000, 32'd0,          3'b100};
    vecs[7] = '{0, 32'h8000_0000,  32'd1,          FN_SUB,    32'h7fff_ffff,  3'b010};

    // Reset with every requester active: all outputs must read zero.
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        rsp_ready[k][p] = 1'b0;
        set_req(k, p, 32'd9, 32'd4, FN_ADD);
      end
    end
    set_req(0, 0, 32'd7, 32'd7, FN_SUB);
    set_req(0, 1, 32'd1, 32'd1, FN_ADD);
    step();
    step();
    #1;
    check("reset_outputs_lat1", any_out(0), 1'b0);
    check("reset_outputs_lat3", any_out(1), 1'b0);
    req_valid[1][0] = 1'b0;
    req_valid[1][1] = 1'b0;
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;

    // Both ports held valid from reset: grants go 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 32'd7, 32'd7, FN_SUB);
      set_req(0, 1, 32'd1, 32'd1, FN_ADD);
      if (i % 2 == 0) serve(0, 0, 32'd7, 32'd7, FN_SUB, 32'd0, 3'b100, 0, 1'b0);
      else            serve(0, 1, 32'd1, 32'd1, FN_ADD, 32'd2, 3'b000, 0, 1'b0);
    end
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;

    // Table of single transactions on both latencies.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        req_valid[k][0] = 1'b0;
        req_valid[k][1] = 1'b0;
        set_req(k, vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].fn);
        serve(k, vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].fn, vecs[i].y, vecs[i].zvn,
              i % 2, 1'b0);
      end
    end

    // Backpressure: rsp1_ready is held low for 10 cycles while req0 waits.
    // Port 0 must be accepted in the cycle after RESP exits.
    set_req(1, 1, 32'd100, 32'd23, FN_ADD);
    req_a[1][0]  = 32'd5;
    req_b[1][0]  = 32'd9;
    req_fn[1][0] = FN_SUB;
    serve(1, 1, 32'd100, 32'd23, FN_ADD, 32'd123, 3'b000, 10, 1'b1);
    serve(1, 0, 32'd5, 32'd9, FN_SUB, 32'hffff_fffc, 3'b001, 0, 1'b0);

    // Reset during EXEC aborts the operation with no response.
    req_valid[1][0] = 1'b0;
    set_req(1, 1, 32'h11, 32'h22, FN_ADD);
    #1;
    check("abort_grant", {req_ready[1][1], req_ready[1][0]}, 2'b10);
    step();
    req_valid[1][1] = 1'b0;
    step();
    rsp_ready[1][0] = 1'b1;
    rsp_ready[1][1] = 1'b1;
    reset_n[1]      = 1'b0;
    #1;
    check("reset_async_zero", any_out(1), 1'b0);
    step();
    step();
    reset_n[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("no_rsp_after_abort", {rsp_valid[1][1], rsp_valid[1][0]}, 2'b00);
      step();
    end
    rsp_ready[1][0] = 1'b0;
    rsp_ready[1][1] = 1'b0;
    set_req(1, 0, 32'd40, 32'd2, FN_ADD);
    set_req(1, 1, 32'd50, 32'd3, FN_ADD);
    serve(1, 0, 32'd40, 32'd2, FN_ADD, 32'd42, 3'b000, 0, 1'b0);
    req_valid[1][1] = 1'b0;

    // Fresh reset of both instances, then random traffic against the model.
    for (int k = 0; k < 2; k++) begin
      reset_n[k]      = 1'b0;
      req_valid[k][0] = 1'b0;
      req_valid[k][1] = 1'b0;
      last_srv[k]     = 1'b1;
    end
    step();
    step();
    for (int k = 0; k < 2; k++) reset_n[k] = 1'b1;

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        pat = 2'($urandom_range(1, 3));
        for (int p = 0; p < 2; p++) begin
          req_valid[k][p] = pat[p];
          req_a[k][p]     = $urandom;
          req_b[k][p]     = ($urandom_range(0, 3) == 0) ? req_a[k][p] : $urandom;
          case ($urandom_range(0, 3))
            0:       req_fn[k][p] = FN_ADD;
            1:       req_fn[k][p] = FN_SUB;
            default: req_fn[k][p] = 6'($urandom);
          endcase
        end
        if (pat == 2'b11) win = last_srv[k] ? 0 : 1;
        else              win = (pat == 2'b10) ? 1 : 0;
        exp_r = alu_fun(req_a[k][win], req_b[k][win], req_fn[k][win]);
        serve(k, win, req_a[k][win], req_b[k][win], req_fn[k][win], exp_r[34:3], exp_r[2:0],
              $urandom_range(0, 3), 1'b0);
        last_srv[k] = (win == 1);
      end
      req_valid[k][0] = 1'b0;
      req_valid[k][1] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
